// File: rtl/sm3_cmprss_core.sv
// sm3_cmprss_core: SM3 compression function, one round per accepted expansion beat
module sm3_cmprss_core (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  expnd_inpt_wj_i,
  input  logic [31:0]  expnd_inpt_wjj_i,
  input  logic         expnd_inpt_vld_i,
  input  logic         expnd_inpt_lst_i,
  output logic         expnd_otpt_ena_o,
  output logic [255:0] cmprss_otpt_res_o,
  output logic         cmprss_otpt_vld_o
);
  typedef enum logic [1:0] {IDLE, RND, FOLD, OUT} state_t;
  localparam logic [255:0] IV = 256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
  state_t state_q, state_d;
  logic [5:0] j_q, j_d;
  logic [255:0] v_q, v_d, w_q, w_d, res_q, res_d, rnd, fold;
  logic lst_q, lst_d, vld_q, vld_d, hi;
  logic [31:0] a, b, c, d, e, f, g, h, tj, a12, ss1, ss2, ff, gg, tt1, tt2;
  function automatic logic [31:0] rol(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction
  assign {a, b, c, d, e, f, g, h} = w_q;
  assign hi  = j_q >= 6'd16;
  assign tj  = hi ? 32'h7a879d8a : 32'h79cc4519;
  assign a12 = rol(a, 5'd12);
  assign ss1 = rol(a12 + e + rol(tj, j_q[4:0]), 5'd7);
  assign ss2 = ss1 ^ a12;
  assign ff  = hi ? (a & b) | (a & c) | (b & c) : a ^ b ^ c;
  assign gg  = hi ? (e & f) | (~e & g) : e ^ f ^ g;
  assign tt1 = ff + d + ss2 + expnd_inpt_wjj_i;
  assign tt2 = gg + h + ss1 + expnd_inpt_wj_i;
  assign rnd = {tt1, a, rol(b, 5'd9), c, tt2 ^ rol(tt2, 5'd9) ^ rol(tt2, 5'd17), e, rol(f, 5'd19), g};
  assign fold = v_q ^ w_q;
  assign expnd_otpt_ena_o  = (state_q == IDLE) || (state_q == RND);
  assign cmprss_otpt_res_o = res_q;
  assign cmprss_otpt_vld_o = vld_q;
  // next state: rounds on accepted beats, fold into V, publish on last block
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    v_d     = v_q;
    w_d     = w_q;
    lst_d   = lst_q;
    res_d   = res_q;
    vld_d   = 1'b0;
    case (state_q)
      IDLE, RND: if (expnd_inpt_vld_i) begin
        w_d     = rnd;
        j_d     = j_q + 6'd1;
        state_d = (j_q == 6'd63) ? FOLD : RND;
        lst_d   = (j_q == 6'd63) ? expnd_inpt_lst_i : lst_q;
      end
      FOLD: begin
        v_d     = fold;
        w_d     = fold;
        res_d   = lst_q ? fold : res_q;
        vld_d   = lst_q;
        state_d = lst_q ? OUT : IDLE;
      end
      default: begin
        v_d     = IV;
        w_d     = IV;
        state_d = IDLE;
      end
    endcase
  end
  // state registers with asynchronous reset to a fresh message
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      v_q     <= IV;
      w_q     <= IV;
      lst_q   <= 1'b0;
      res_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      v_q     <= v_d;
      w_q     <= w_d;
      lst_q   <= lst_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end
endmodule

// File: tb/tb_sm3_cmprss_core.sv
// tb_sm3_cmprss_core: directed SM3 vectors against known digests
module tb_sm3_cmprss_core;
  localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK1 = {16{32'h61626364}};
  localparam logic [511:0] BLK2 = {32'h80000000, 448'h0, 32'h00000200};
  localparam logic [255:0] ABC_H  = 256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
  localparam logic [255:0] ABCD_H = 256'hdebe9ff9_2275b8a1_38604889_c18e5a4d_6fdb70e5_387e5765_293dcba3_9c0c5732;
  logic clk = 0, rst = 1;
  logic [31:0] wj = 0, wjj = 0;
  logic vld = 0, lst = 0;
  logic ena, vld_o;
  logic [255:0] res;
  int total = 0, bad = 0, cyc = 0, hi_cnt = 0, p_cyc = 0, p_prev = 0, acc_cyc = 0, first_stall = 0, h0;
  logic [31:0] wx [68];
  logic [31:0] wpx [64];
  sm3_cmprss_core dut (
    .clk(clk), .rst(rst),
    .expnd_inpt_wj_i(wj), .expnd_inpt_wjj_i(wjj),
    .expnd_inpt_vld_i(vld), .expnd_inpt_lst_i(lst),
    .expnd_otpt_ena_o(ena),
    .cmprss_otpt_res_o(res), .cmprss_otpt_vld_o(vld_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (vld_o) begin
    hi_cnt = hi_cnt + 1;
    p_prev = p_cyc;
    p_cyc = cyc;
  end
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  task automatic expand(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) wx[i] = blk[511 - 32 * i -: 32];
    for (int i = 16; i < 68; i++) begin
      logic [31:0] x;
      x = wx[i-16] ^ wx[i-9] ^ rl(wx[i-3], 15);
      wx[i] = (x ^ rl(x, 15) ^ rl(x, 23)) ^ rl(wx[i-13], 7) ^ wx[i-6];
    end
    for (int i = 0; i < 64; i++) wpx[i] = wx[i] ^ wx[i+4];
  endtask
  task automatic send_block(input logic [511:0] blk, input logic l, input logic bub, input logic noise, input int nr);
    expand(blk);
    for (int j = 0; j < nr; j++) begin
      int stall;
      if (bub && $urandom_range(0, 9) < 3) begin
        vld = 0; wj = $urandom; wjj = $urandom; lst = 1'($urandom);
        @(posedge clk); #1;
      end
      vld = 1; wj = wx[j]; wjj = wpx[j];
      lst = (j == 63) ? l : (noise ? 1'($urandom) : 1'b0);
      stall = 0;
      while (!ena && stall < 200) begin
        @(posedge clk); #1;
        stall++;
      end
      if (stall >= 200) chk("ena_timeout", 256'(ena), 256'(1));
      if (j == 0) first_stall = stall;
      @(posedge clk); #1;
      acc_cyc = cyc;
      wj = $urandom; wjj = $urandom; lst = 1'($urandom);
    end
  endtask
  task automatic finish_msg();
    repeat (2) @(posedge clk);
    #1 vld = 0;
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 256'(vld_o), 256'(0));
    chk("rst_res", res, 256'h0);
    chk("rst_ena", 256'(ena), 256'(1));
    rst = 0;
    h0 = hi_cnt;
    send_block(ABC, 1, 0, 0, 64);
    finish_msg();
    chk("abc_res", res, ABC_H);
    chk("abc_pulses", 256'(hi_cnt - h0), 256'(1));
    chk("abc_latency", 256'(p_cyc - acc_cyc), 256'(1));
    repeat (5) @(posedge clk);
    #1;
    chk("abc_hold", res, ABC_H);
    chk("abc_vld_low", 256'(vld_o), 256'(0));
    h0 = hi_cnt;
    send_block(ABC, 1, 0, 0, 64);
    send_block(ABC, 1, 0, 0, 64);
    chk("b2b_stall", 256'(first_stall), 256'(2));
    finish_msg();
    chk("b2b_pulses", 256'(hi_cnt - h0), 256'(2));
    chk("b2b_spacing", 256'(p_cyc - p_prev), 256'(66));
    chk("b2b_res", res, ABC_H);
    h0 = hi_cnt;
    send_block(BLK1, 0, 0, 1, 64);
    send_block(BLK2, 1, 0, 1, 64);
    chk("two_stall", 256'(first_stall), 256'(1));
    finish_msg();
    chk("two_pulses", 256'(hi_cnt - h0), 256'(1));
    chk("two_res", res, ABCD_H);
    h0 = hi_cnt;
    send_block(ABC, 1, 1, 1, 64);
    finish_msg();
    chk("bub_pulses", 256'(hi_cnt - h0), 256'(1));
    chk("bub_res", res, ABC_H);
    send_block(BLK1, 1, 0, 0, 30);
    vld = 0;
    rst = 1;
    #1;
    chk("mid_rst_res", res, 256'h0);
    chk("mid_rst_ena", 256'(ena), 256'(1));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("mid_rst_vld", 256'(vld_o), 256'(0));
    end
    rst = 0;
    h0 = hi_cnt;
    send_block(ABC, 1, 0, 0, 64);
    finish_msg();
    chk("after_rst_pulses", 256'(hi_cnt - h0), 256'(1));
    chk("after_rst_res", res, ABC_H);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sm3_cmprss_core.md
SM3_CMPRSS_CORE -- requirements
Module: sm3_cmprss_core

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 rst  input  1  reset, asynchronous assert, active-high.
REQ-003 expnd_inpt_wj_i  input  32  message-expansion word Wj for round j.
REQ-004 expnd_inpt_wjj_i  input  32  expansion word W'j = Wj ^ Wj+4 for round j.
REQ-005 expnd_inpt_vld_i  input  1  Wj/W'j beat valid.
REQ-006 expnd_inpt_lst_i  input  1  beat belongs to final 512-bit block of message; sampled only on round-63 beat.
REQ-007 expnd_otpt_ena_o  output  1  ready to the expansion stage; beat transfers when vld & ena both high.
REQ-008 cmprss_otpt_res_o  output  256  final hash, A..H order, V0 (A) in [255:224].
REQ-009 cmprss_otpt_vld_o  output  1  one-cycle pulse, res valid.

Function
REQ-010 States SHALL be IDLE, RND, FOLD, OUT; 6-bit round counter j; 256-bit chaining register V; working registers A..H.
REQ-011 IV SHALL be 7380166f 4914b2b9 172442d7 da8a0600 a96f30bc 163138aa e38dee4d b0fb0e4e.
REQ-012 expnd_otpt_ena_o SHALL be 1 in IDLE and RND, 0 in FOLD and OUT.
REQ-013 In IDLE, A..H SHALL equal V; accepted beat executes round 0, j->1, state->RND.
REQ-014 In RND, each accepted beat executes round j, j increments; vld low = bubble, no register change.
REQ-015 Round j (mod 2^32, <<< = rotate-left): SS1=((A<<<12)+E+(Tj<<<(j mod 32)))<<<7; SS2=SS1^(A<<<12); TT1=FFj(A,B,C)+D+SS2+W'j; TT2=GGj(E,F,G)+H+SS1+Wj.
REQ-016 Update: D<=C, C<=B<<<9, B<=A, A<=TT1, H<=G, G<=F<<<19, F<=E, E<=P0(TT2); P0(X)=X^(X<<<9)^(X<<<17).
REQ-017 Tj=79cc4519 for j<=15, 7a879d8a for j>=16; FF/GG = X^Y^Z for j<=15; FF=majority(X,Y,Z), GG=(X&Y)|(~X&Z) for j>=16.
REQ-018 Round-63 beat SHALL latch lst, j wraps to 0, state->FOLD.
REQ-019 FOLD (1 cycle): V<=V^{A..H}, A..H<=V^{A..H}; lst=0 -> IDLE; lst=1 -> OUT.
REQ-020 OUT (1 cycle): res_o<=V, vld_o=1; V and A..H<=IV; ->IDLE.
REQ-021 Latency: round-63 beat accepted cycle T -> vld_o high cycle T+2; ena_o high again from T+2 (non-last) or T+3 (last).
REQ-022 res_o SHALL hold last result until the next OUT; vld_o is exactly one cycle.
REQ-023 lst on beats other than round 63 SHALL be ignored; vld during FOLD/OUT SHALL be ignored (not accepted).
REQ-024 Throughput: one round per cycle with continuous vld; 66 cycles per block incl. FOLD/OUT.

Reset
REQ-025 rst asserted SHALL immediately force state IDLE, j=0, V=A..H=IV, res_o=0, vld_o=0; ena_o=1 once in IDLE.
REQ-026 rst mid-block SHALL discard the partial block and chaining state; next accepted beat is round 0 of a new message with IV.

Verification
REQ-027 "abc" single padded block, lst=1, continuous vld -> one vld_o pulse, res=66c7f0f4 62eeedd9 d1f2d46b dc10e4e2 4167c487 5cf2f7a2 297da02b 8f4ba8e0, exactly 2 cycles after 64th beat.
REQ-028 "abcd"x16 (two blocks, lst=1 only on block 2) -> no vld after block 1, ena_o low 1 cycle, final res=debe9ff9 2275b8a1 38604889 c18e5a4d 6fdb70e5 387e5765 293dcba3 9c0c5732.
REQ-029 "abc" with random vld bubbles (~30%) -> identical result to REQ-027; no round consumed on bubble cycles.
REQ-030 rst pulse at round 30 of a block, then full "abc" -> res per REQ-027; vld_o 0 throughout reset.
REQ-031 vld held high during FOLD/OUT, lst toggled on rounds 0-62 -> no extra beat accepted, lst ignored, result unchanged.
REQ-032 Back-to-back "abc" messages -> two pulses 66 cycles apart, both equal to REQ-027 (V reinitialised to IV).
